nfa_match_collector: RTL and testbench

Downstream stage for a bank of NFA regex engines sharing one byte stream. It watches each engine's sticky `out` match flag and detects the first assertion per stream. It tags each match with the byte offset of the triggering character and serialises simultaneous matches into a record FIFO for host readout. It sits between the engine array and the host/status interface, on the same `clk`/`en`/`sod` byte stream as the engines.

---
 rtl/nfa_match_collector.sv | 130 +++++++++++++
 tb/tb_nfa_match_collector.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nfa_match_collector.sv
// rtl/nfa_match_collector.sv - first-match edge detect, byte-offset tagging and record FIFO for an NFA engine bank
// Optional saturating drop counter enabled by NFA_MATCH_COLL_DROP_CNT_EN.
module nfa_match_collector #(
  parameter int N_ENG = 8,
  parameter int ID_W  = 3,
  parameter int POS_W = 16,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sod,
  input  logic [N_ENG-1:0]        match_vec,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [ID_W+POS_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [POS_W-1:0] POS_MAX = '1;

  logic [POS_W-1:0]      pos;
  logic [POS_W-1:0]      new_off;
  logic [POS_W-1:0]      off [N_ENG];
  logic [N_ENG-1:0]      prev;
  logic [N_ENG-1:0]      pending;
  logic [N_ENG-1:0]      rise;
  logic [N_ENG-1:0]      lowest;
  logic [N_ENG-1:0]      grant;
  logic [ID_W-1:0]       gnt_id;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [ID_W+POS_W-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  assign rise     = match_vec & ~prev;
  assign full     = (level == (AW+1)'(DEPTH));
  assign push     = (|pending) & ~full;
  assign pop      = rd_valid & rd_ready;
  assign rd_valid = (level != '0);
  assign rd_data  = mem[rd_ptr];

  // Engine outputs lag their byte by one edge, so the triggering byte is pos-1.
  always_comb begin
    if (pos == '0)
      new_off = '0;
    else if (pos == POS_MAX)
      new_off = POS_MAX;
    else
      new_off = pos - POS_W'(1);
  end

  always_comb begin
    lowest = pending & (~pending + N_ENG'(1));
    grant  = push ? lowest : '0;
    gnt_id = '0;
    for (int i = 0; i < N_ENG; i++)
      if (lowest[i])
        gnt_id = ID_W'(i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos     <= '0;
      prev    <= '0;
      pending <= '0;
      for (int i = 0; i < N_ENG; i++)
        off[i] <= '0;
    end else if (sod) begin
      pos     <= '0;
      prev    <= '0;
      pending <= '0;
      for (int i = 0; i < N_ENG; i++)
        off[i] <= '0;
    end else begin
      if (en && (pos != POS_MAX))
        pos <= pos + POS_W'(1);
      prev    <= match_vec;
      pending <= (pending & ~grant) | rise;
      for (int i = 0; i < N_ENG; i++)
        if (rise[i])
          off[i] <= new_off;
    end
  end

  // FIFO runs independently of sod so queued records survive a stream restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {gnt_id, off[gnt_id]};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef NFA_MATCH_COLL_DROP_CNT_EN
  logic [N_ENG-1:0] dropped;
  logic [8:0]       drop_sum;

  always_comb begin
    dropped  = pending & ~grant;
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < N_ENG; i++)
      drop_sum = drop_sum + 9'(dropped[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if (sod)
      drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_nfa_match_collector.sv
// tb/tb_nfa_match_collector.sv - scoreboard bench for nfa_match_collector
// Reference model tracks first-assertion per stream and a queue of expected records.
module tb_nfa_match_collector;

  localparam int N   = 8;
  localparam int IDW = 3;
  localparam int PW  = 4;
  localparam int D   = 16;
  localparam int PMAX = (1 << PW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           sod = 1'b0;
  logic [N-1:0]   match_vec = '0;
  logic           rd_ready = 1'b0;
  logic           rd_valid;
  logic [IDW+PW-1:0] rd_data;
  logic [$clog2(D):0] level;
  logic [7:0]     drop_cnt;

  nfa_match_collector #(.N_ENG(N), .ID_W(IDW), .POS_W(PW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .sod(sod), .match_vec(match_vec),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [IDW+PW-1:0] exp_q[$];
  int         m_cnt = 0;
  int         m_drop = 0;
  int         m_bytes = 0;
  bit [N-1:0] m_seen = '0;
  bit [N-1:0] m_pend = '0;
  int         m_off[N];
  int         exp_level = 0;
  int         exp_drop = 0;
  logic [N-1:0] cur_mv = '0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One upcoming clock edge of the reference behaviour, using the inputs now driven.
  task automatic model_step();
    bit pop;
    bit pushed;
    pop = (m_cnt > 0) && rd_ready;
    pushed = 1'b0;
    if (m_cnt < D) begin
      for (int i = 0; i < N; i++) begin
        if (!pushed && m_pend[i]) begin
          exp_q.push_back({IDW'(i), PW'(m_off[i])});
          m_pend[i] = 1'b0;
          pushed = 1'b1;
        end
      end
    end
    m_cnt = m_cnt + int'(pushed) - int'(pop);
    if (sod) begin
`ifdef NFA_MATCH_COLL_DROP_CNT_EN
      for (int i = 0; i < N; i++)
        if (m_pend[i] && m_drop < 255)
          m_drop++;
`endif
      m_pend  = '0;
      m_seen  = '0;
      m_bytes = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (match_vec[i] && !m_seen[i]) begin
          m_seen[i] = 1'b1;
          m_pend[i] = 1'b1;
          m_off[i]  = (m_bytes == 0) ? 0 : (m_bytes == PMAX) ? PMAX : m_bytes - 1;
        end
      end
      if (en && m_bytes < PMAX)
        m_bytes++;
    end
  endtask

  task automatic cyc(input logic e, input logic s, input logic [N-1:0] mv, input logic r);
    en = e;
    sod = s;
    match_vec = mv;
    cur_mv = mv;
    rd_ready = r;
    model_step();
    @(posedge clk);
    #1;
    exp_level = m_cnt;
    exp_drop  = m_drop;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, cur_mv, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_cnt = 0; m_drop = 0; m_bytes = 0; m_seen = '0; m_pend = '0;
    exp_q.delete();
    exp_level = 0; exp_drop = 0;
    en = 1'b0; sod = 1'b0; match_vec = '0; cur_mv = '0; rd_ready = 1'b0;
    #2;
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compares DUT state each negedge and pops records on handshake.
  logic [IDW+PW-1:0] exp_rec;
  always @(negedge clk) begin
    check("rd_valid", int'(rd_valid), int'(exp_level != 0));
    check("level", int'(level), exp_level);
    check("drop_cnt", int'(drop_cnt), exp_drop);
    if (rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL record: got %h with no record expected at %0t", rd_data, $time);
      end else begin
        exp_rec = exp_q.pop_front();
        check("record", int'(rd_data), int'(exp_rec));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int rdy_mode;
    logic e, s, r;
    logic [N-1:0] mv;

    repeat (3) @(posedge clk);
    #1;
    check("init_level", int'(level), 0);
    rst = 1'b1;

    // Reset mid-stream with three records queued
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h07, 0);
    repeat (4) cyc(1, 0, 8'h07, 0);
    check("pre_rst_level", int'(level), 3);
    do_reset();

    // First match at byte 4
    repeat (5) cyc(1, 0, 8'h00, 0);
    cyc(0, 0, 8'h04, 0);
    cyc(0, 0, 8'h04, 0);
    check("first_rec", int'(rd_data), int'({3'd2, 4'd4}));
    drain(4);

    // Simultaneous rises after byte 9
    cyc(0, 1, 8'h00, 1);
    repeat (10) cyc(1, 0, 8'h00, 0);
    cyc(0, 0, 8'h29, 0);
    repeat (3) cyc(0, 0, 8'h29, 0);
    check("simul_level", int'(level), 3);
    drain(5);

    // Sticky output then re-assert after restart
    cyc(0, 1, 8'h00, 1);
    repeat (50) cyc(1, 0, 8'h02, 1);
    cyc(0, 1, 8'h00, 1);
    repeat (3) cyc(1, 0, 8'h00, 1);
    cyc(0, 0, 8'h02, 0);
    cyc(0, 0, 8'h02, 0);
    check("sticky_rec", int'(rd_data), int'({3'd1, 4'd2}));
    drain(4);

    // Backpressure: fill the FIFO and leave two matches pending
    cyc(0, 1, 8'h00, 0);
    repeat (10) cyc(0, 0, 8'hff, 0);
    cyc(0, 1, 8'h00, 0);
    repeat (10) cyc(0, 0, 8'hff, 0);
    cyc(0, 1, 8'h00, 0);
    repeat (3) cyc(0, 0, 8'h03, 0);
    check("full_level", int'(level), 16);
    cyc(0, 1, 8'h00, 0);
`ifdef NFA_MATCH_COLL_DROP_CNT_EN
    check("drop_after_sod", int'(drop_cnt), 2);
`else
    check("drop_after_sod", int'(drop_cnt), 0);
`endif
    check("level_after_sod", int'(level), 16);
    repeat (3) cyc(0, 0, 8'h03, 0);
    cyc(0, 0, 8'h03, 1);
    check("level_after_pop", int'(level), 15);
    cyc(0, 0, 8'h03, 0);
    check("level_after_refill", int'(level), 16);
    drain(30);

    // Offset saturation with a 4-bit counter
    cyc(0, 1, 8'h00, 1);
    repeat (20) cyc(1, 0, 8'h00, 1);
    cyc(0, 0, 8'h40, 0);
    cyc(0, 0, 8'h40, 0);
    check("sat_rec", int'(rd_data), int'({3'd6, 4'd15}));
    drain(4);

    // Randomized traffic
    rdy_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0)
        rdy_mode = $urandom_range(0, 2);
      s = ($urandom_range(0, 99) < 3);
      e = ($urandom_range(0, 99) < 70);
      mv = cur_mv;
      if (s)
        mv = '0;
      else if ($urandom_range(0, 99) < 8)
        mv = mv | N'(1 << $urandom_range(0, N-1));
      case (rdy_mode)
        0: r = 1'b0;
        1: r = ($urandom_range(0, 99) < 30);
        default: r = ($urandom_range(0, 99) < 90);
      endcase
      cyc(e, s, mv, r);
    end

    drain(60);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_level", int'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
